// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: owns the PC, requests words from instruction memory,
// holds one fetched instruction for decode, and redirects on taken ALU branches.
module fetch_unit #(
  parameter int                    PC_WIDTH    = 16,
  parameter int                    INSTR_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   branch_valid,
  input  logic                   compres,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [15:0]            taken_count
);

  typedef enum logic {S_FETCH, S_HALTED} state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_instr_pc;
  logic                   r_instr_valid;
  logic [15:0]            r_taken_count;
  logic                   w_taken;
  logic                   w_req;
  logic                   w_fire;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_taken = branch_valid & compres & (r_state == S_FETCH);
  assign w_fire  = w_req & imem_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_state_next;
  end

  // A taken branch defers halting by one cycle so the redirect lands first.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    if (r_state == S_FETCH) begin
      w_req = reset_n & ~(halt | w_taken) & (~r_instr_valid | instr_ready);
      if (halt && !w_taken) w_state_next = S_HALTED;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_taken_count <= '0;
    end else if (w_taken) begin
      r_pc          <= branch_target;
      r_instr_valid <= 1'b0;
      r_taken_count <= sat_inc(r_taken_count);
    end else if (w_fire) begin
      r_instr       <= imem_rdata;
      r_instr_pc    <= r_pc;
      r_instr_valid <= 1'b1;
      r_pc          <= r_pc + PC_ONE;
    end else if (instr_ready && r_instr_valid) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = (r_state == S_HALTED);
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked against
// a transaction-level model of the fetch stage kept in this file.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        branch_valid;
  logic        compres;
  logic [15:0] branch_target;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [8:0]  imem_rdata;
  logic [8:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] salt;

  // Model state
  logic [15:0] m_pc;
  logic [8:0]  m_instr;
  logic [15:0] m_instr_pc;
  logic        m_valid;
  logic        m_halted;
  int          m_count;

  fetch_unit #(.PC_WIDTH(16), .INSTR_WIDTH(9), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n), .branch_valid(branch_valid), .compres(compres),
    .branch_target(branch_target), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .halted(halted),
    .taken_count(taken_count)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'd37;
    return p[8:0] ^ a[15:7] ^ salt;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  function automatic logic exp_req();
    if (!reset_n || m_halted) return 1'b0;
    if (halt || (branch_valid && compres)) return 1'b0;
    return !m_valid || instr_ready;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic req;
    req = exp_req();
    if (!reset_n) begin
      m_pc = 16'h0; m_instr = 9'h0; m_instr_pc = 16'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_count = 0;
    end else if (m_halted) begin
      if (instr_ready) m_valid = 1'b0;
    end else if (branch_valid && compres) begin
      m_pc = branch_target;
      m_valid = 1'b0;
      if (m_count < 65535) m_count = m_count + 1;
    end else begin
      if (req && imem_ready) begin
        m_instr = mem_word(m_pc); m_instr_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
      end else if (instr_ready) begin
        m_valid = 1'b0;
      end
      if (halt) m_halted = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    branch_valid = 0; compres = 0; branch_target = 16'h0; halt = 0;
    imem_ready = 0; instr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    if (pc !== 16'h0) begin n_err++; $display("FAIL reset_pc act=%0h exp=0", pc); end
    n_cmp++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_err++; $display("FAIL reset_flags valid=%0b halted=%0b exp=0/0", instr_valid, halted);
    end
    n_cmp++;
    if (taken_count !== 16'h0 || instr !== 9'h0 || instr_pc !== 16'h0) begin
      n_err++; $display("FAIL reset_data cnt=%0h instr=%0h ipc=%0h exp=0", taken_count, instr, instr_pc);
    end
    n_cmp++;
  endtask

  task automatic test_stream();
    do_reset();
    imem_ready = 1; instr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
        n_err++; $display("FAIL stream_addr req=%0b addr=%0h exp=1/%0h", imem_req, imem_addr, k);
      end
      n_cmp++;
      tick();
      if (instr_valid !== 1'b1 || instr_pc !== 16'(k) || instr !== mem_word(16'(k))) begin
        n_err++; $display("FAIL stream_instr v=%0b ipc=%0h instr=%0h exp=1/%0h/%0h",
                          instr_valid, instr_pc, instr, k, mem_word(16'(k)));
      end
      n_cmp++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_ready = 1; instr_ready = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req act=%0b exp=0", imem_req); end
      n_cmp++;
      tick();
      if (instr_pc !== 16'h0 || instr !== mem_word(16'h0) || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold ipc=%0h instr=%0h v=%0b exp=0/%0h/1",
                          instr_pc, instr, instr_valid, mem_word(16'h0));
      end
      n_cmp++;
    end
    instr_ready = 1;
    #1;
    if (imem_req !== 1'b1 || imem_addr !== 16'h1) begin
      n_err++; $display("FAIL bp_resume req=%0b addr=%0h exp=1/1", imem_req, imem_addr);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    imem_ready = 1; instr_ready = 1;
    repeat (5) tick();
    branch_valid = 1; compres = 1; branch_target = 16'h0040;
    #1;
    if (imem_req !== 1'b0 || instr_pc !== 16'h4 || pc !== 16'h5) begin
      n_err++; $display("FAIL br_setup req=%0b ipc=%0h pc=%0h exp=0/4/5", imem_req, instr_pc, pc);
    end
    n_cmp++;
    tick();
    branch_valid = 0; compres = 0;
    #1;
    if (instr_valid !== 1'b0 || taken_count !== 16'h1 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_err++; $display("FAIL br_taken v=%0b cnt=%0h req=%0b addr=%0h exp=0/1/1/40",
                        instr_valid, taken_count, imem_req, imem_addr);
    end
    n_cmp++;
    tick();
    branch_valid = 1; compres = 0; branch_target = 16'h0100;
    tick();
    tick();
    branch_valid = 0;
    if (pc !== 16'h0043 || taken_count !== 16'h1 || instr_pc !== 16'h0042) begin
      n_err++; $display("FAIL br_not_taken pc=%0h cnt=%0h ipc=%0h exp=43/1/42", pc, taken_count, instr_pc);
    end
    n_cmp++;
    compres = 1;
    tick();
    compres = 0;
    if (pc !== 16'h0044 || taken_count !== 16'h1) begin
      n_err++; $display("FAIL br_cmp_only pc=%0h cnt=%0h exp=44/1", pc, taken_count);
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    imem_ready = 1; instr_ready = 1;
    branch_valid = 1; compres = 1; branch_target = 16'hFFFF;
    tick();
    branch_valid = 0; compres = 0;
    tick();
    if (pc !== 16'h0 || instr_pc !== 16'hFFFF || instr !== mem_word(16'hFFFF)) begin
      n_err++; $display("FAIL wrap pc=%0h ipc=%0h instr=%0h exp=0/ffff/%0h", pc, instr_pc, instr, mem_word(16'hFFFF));
    end
    n_cmp++;
  endtask

  task automatic test_halt_branch();
    logic [15:0] cnt0;
    do_reset();
    imem_ready = 1; instr_ready = 0;
    tick();
    cnt0 = taken_count;
    halt = 1; branch_valid = 1; compres = 1; branch_target = 16'h0010;
    tick();
    branch_valid = 0; compres = 0;
    #1;
    if (pc !== 16'h0010 || halted !== 1'b0 || imem_req !== 1'b0 || taken_count !== cnt0 + 16'd1) begin
      n_err++; $display("FAIL hb_branch pc=%0h halted=%0b req=%0b cnt=%0h exp=10/0/0/%0h",
                        pc, halted, imem_req, taken_count, cnt0 + 16'd1);
    end
    n_cmp++;
    tick();
    halt = 0; instr_ready = 1;
    branch_valid = 1; compres = 1; branch_target = 16'h0099;
    #1;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL hb_halted halted=%0b req=%0b exp=1/0", halted, imem_req);
    end
    n_cmp++;
    tick();
    tick();
    if (pc !== 16'h0010 || taken_count !== cnt0 + 16'd1 || halted !== 1'b1) begin
      n_err++; $display("FAIL hb_ignore pc=%0h cnt=%0h halted=%0b exp=10/%0h/1", pc, taken_count, halted, cnt0 + 16'd1);
    end
    n_cmp++;
    do_reset();
    if (pc !== 16'h0 || halted !== 1'b0) begin
      n_err++; $display("FAIL hb_reset pc=%0h halted=%0b exp=0/0", pc, halted);
    end
    n_cmp++;
  endtask

  task automatic test_halt_drain();
    do_reset();
    imem_ready = 1; instr_ready = 0;
    tick();
    halt = 1;
    tick();
    halt = 0;
    if (halted !== 1'b1 || instr_valid !== 1'b1 || pc !== 16'h1) begin
      n_err++; $display("FAIL hd_hold halted=%0b v=%0b pc=%0h exp=1/1/1", halted, instr_valid, pc);
    end
    n_cmp++;
    instr_ready = 1;
    tick();
    if (instr_valid !== 1'b0 || pc !== 16'h1) begin
      n_err++; $display("FAIL hd_drain v=%0b pc=%0h exp=0/1", instr_valid, pc);
    end
    n_cmp++;
  endtask

  task automatic test_reset_pending();
    do_reset();
    imem_ready = 1; instr_ready = 1;
    repeat (3) tick();
    branch_valid = 1; compres = 1; branch_target = 16'h0200;
    tick();
    branch_valid = 0; compres = 0; imem_ready = 0;
    #1;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL rp_pending req=%0b exp=1", imem_req); end
    n_cmp++;
    reset_n = 0;
    #1;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rp_req_in_reset req=%0b exp=0", imem_req); end
    n_cmp++;
    tick();
    if (pc !== 16'h0 || taken_count !== 16'h0 || instr_valid !== 1'b0 || instr !== 9'h0 ||
        instr_pc !== 16'h0 || halted !== 1'b0) begin
      n_err++; $display("FAIL rp_outputs pc=%0h cnt=%0h v=%0b instr=%0h ipc=%0h halted=%0b exp=all 0",
                        pc, taken_count, instr_valid, instr, instr_pc, halted);
    end
    n_cmp++;
    reset_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      imem_ready    = ($urandom_range(0, 9) < 7);
      instr_ready   = ($urandom_range(0, 9) < 6);
      branch_valid  = ($urandom_range(0, 9) < 2);
      compres       = $urandom_range(0, 1) == 1;
      branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      halt          = ($urandom_range(0, 199) == 0);
      #1;
      if (imem_req !== exp_req() || (exp_req() && imem_addr !== m_pc)) begin
        n_err++; $display("FAIL rnd_req i=%0d req=%0b addr=%0h exp=%0b/%0h", i, imem_req, imem_addr, exp_req(), m_pc);
      end
      n_cmp++;
      tick();
      if (pc !== m_pc || instr_valid !== m_valid || halted !== m_halted ||
          taken_count !== 16'(m_count) || (m_valid && (instr !== m_instr || instr_pc !== m_instr_pc))) begin
        n_err++; $display("FAIL rnd_state i=%0d pc=%0h v=%0b h=%0b cnt=%0h instr=%0h ipc=%0h exp=%0h/%0b/%0b/%0h/%0h/%0h",
                          i, pc, instr_valid, halted, taken_count, instr, instr_pc,
                          m_pc, m_valid, m_halted, m_count, m_instr, m_instr_pc);
      end
      n_cmp++;
    end
    reset_n = 1;
  endtask

  initial begin
    salt = 9'($urandom);
    reset_n = 0;
    idle_inputs();
    m_pc = 0; m_instr = 0; m_instr_pc = 0; m_valid = 0; m_halted = 0; m_count = 0;
    @(negedge clock);
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap();
    test_halt_branch();
    test_halt_drain();
    test_reset_pending();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
